// File: rtl/cdda_mixer_if.sv
// cdda_mixer_if: signal bundle between the CDDA mixer and its environment.
//   cen_44100        44.1 kHz sample enable (shared with the CDDA FIFO)
//   cdda_l/cdda_r    CDDA stereo sample, signed 16
//   aud_l/aud_r      existing Amiga audio path, signed 16
//   vol_l/vol_r      CDDA volume 0..64 (larger values clamp to 64)
//   mute             drive both CDDA gains toward 0
//   out_l/out_r      mixed, saturated output, signed 16
//   out_valid        one-cycle pulse when out_l/out_r update
// master drives the inputs and observes the outputs; slave is the mixer.
interface cdda_mixer_if;
  logic        cen_44100;
  logic [15:0] cdda_l;
  logic [15:0] cdda_r;
  logic [15:0] aud_l;
  logic [15:0] aud_r;
  logic [6:0]  vol_l;
  logic [6:0]  vol_r;
  logic        mute;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_valid;

  modport master (
    output cen_44100, cdda_l, cdda_r, aud_l, aud_r, vol_l, vol_r, mute,
    input  out_l, out_r, out_valid
  );

  modport slave (
    input  cen_44100, cdda_l, cdda_r, aud_l, aud_r, vol_l, vol_r, mute,
    output out_l, out_r, out_valid
  );
endinterface

// File: rtl/cdda_mixer.sv
// cdda_mixer: scales the CDDA sample pair by a ramped per-channel gain
// (0..64, 64 = unity), adds it to the Amiga audio path and saturates to
// 16-bit signed. A single multiplier is shared between left and right.
// Ports:
//   clk_sys   system clock
//   reset     synchronous, active-high reset
//   bus       cdda_mixer_if.slave (sample inputs, volume/mute, mixed outputs)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for cen_44100
// WAIT  | counting down until the FIFO has updated both channels
// MUL_L | left product through the shared multiplier
// MUL_R | right product through the shared multiplier
// SUM   | add Amiga audio, saturate, register outputs, pulse out_valid
module cdda_mixer #(
  parameter int CAPTURE_DELAY = 3,
  parameter int RAMP_STEP     = 1
) (
  input  logic         clk_sys,
  input  logic         reset,
  cdda_mixer_if.slave  bus
);

  localparam int CW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CAPTURE_DELAY - 1);
  localparam logic [6:0]    STEP     = 7'(RAMP_STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    MUL_L = 3'd2,
    MUL_R = 3'd3,
    SUM   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt;
  logic [6:0]    g_l, g_r;
  logic [15:0]   cap_cl, cap_cr, cap_al, cap_ar;
  logic [16:0]   p_l, p_r;
  logic [15:0]   out_l_q, out_r_q;
  logic          out_valid_q;

  // Moves g one ramp step toward the (clamped, mute-aware) target, landing
  // exactly on the target once it is within a step.
  function automatic logic [6:0] ramp_gain(input logic [6:0] g,
                                           input logic [6:0] vol,
                                           input logic       mu);
    logic [6:0] tgt;
    logic [6:0] res;
    tgt = mu ? 7'd0 : ((vol > 7'd64) ? 7'd64 : vol);
    if (tgt > g) begin
      res = ((tgt - g) <= STEP) ? tgt : (g + STEP);
    end else begin
      res = ((g - tgt) <= STEP) ? tgt : (g - STEP);
    end
    return res;
  endfunction

  function automatic logic [15:0] sat16(input logic signed [17:0] s);
    logic [15:0] res;
    if (s > 18'sd32767) begin
      res = 16'h7FFF;
    end else if (s < -18'sd32768) begin
      res = 16'h8000;
    end else begin
      res = s[15:0];
    end
    return res;
  endfunction

  // Shared multiplier: operands selected by the current MUL state.
  logic signed [15:0] mul_a;
  logic        [6:0]  mul_g;
  logic signed [23:0] prod;
  logic        [16:0] scaled;
  logic               unused_prod_bits;

  assign mul_a  = (state_q == MUL_R) ? $signed(cap_cr) : $signed(cap_cl);
  assign mul_g  = (state_q == MUL_R) ? g_r : g_l;
  assign prod   = mul_a * $signed({1'b0, mul_g});
  // Arithmetic >>> 6 (floor); with gain <= 64 the result fits in 17 bits.
  assign scaled = prod[22:6];
  assign unused_prod_bits = ^{prod[23], prod[5:0]};

  logic signed [17:0] sum_l, sum_r;
  assign sum_l = $signed({p_l[16], p_l}) + $signed({{2{cap_al[15]}}, cap_al});
  assign sum_r = $signed({p_r[16], p_r}) + $signed({{2{cap_ar[15]}}, cap_ar});

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cen_44100) state_d = WAIT;
      WAIT:    if (cnt == '0)     state_d = MUL_L;
      MUL_L:   state_d = MUL_R;
      MUL_R:   state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt         <= '0;
      g_l         <= 7'd0;
      g_r         <= 7'd0;
      cap_cl      <= 16'd0;
      cap_cr      <= 16'd0;
      cap_al      <= 16'd0;
      cap_ar      <= 16'd0;
      p_l         <= 17'd0;
      p_r         <= 17'd0;
      out_l_q     <= 16'd0;
      out_r_q     <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cen_44100) cnt <= CNT_LOAD;
        end
        WAIT: begin
          if (cnt == '0) begin
            cap_cl <= bus.cdda_l;
            cap_cr <= bus.cdda_r;
            cap_al <= bus.aud_l;
            cap_ar <= bus.aud_r;
            g_l    <= ramp_gain(g_l, bus.vol_l, bus.mute);
            g_r    <= ramp_gain(g_r, bus.vol_r, bus.mute);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MUL_L: p_l <= scaled;
        MUL_R: p_r <= scaled;
        SUM: begin
          out_l_q     <= sat16(sum_l);
          out_r_q     <= sat16(sum_r);
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_cdda_mixer.sv
module tb_cdda_mixer;

  localparam int RAMP_STEP = 1;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  cdda_mixer_if bus();

  cdda_mixer #(.CAPTURE_DELAY(3), .RAMP_STEP(RAMP_STEP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gl = 0;
  int   gr = 0;

  function automatic int ramp(input int g, input int vol, input bit mu);
    int t;
    t = mu ? 0 : ((vol > 64) ? 64 : vol);
    if (t > g) return ((t - g) <= RAMP_STEP) ? t : g + RAMP_STEP;
    return ((g - t) <= RAMP_STEP) ? t : g - RAMP_STEP;
  endfunction

  function automatic logic [15:0] mix(input logic [15:0] c, input logic [15:0] a, input int g);
    int p;
    int s;
    p = int'($signed(c));
    p = p * g;
    p = p >>> 6;
    s = p + int'($signed(a));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic apply_reset(input int cycles);
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (cycles) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    gl = 0;
    gr = 0;
    sb.delete();
  endtask

  // Drives one sample, pushes the model's expectation, then watches a fixed
  // window of edges for out_valid (first latency, pulse count, first outputs).
  task automatic run_sample(input logic [15:0] cl, cr, al, ar,
                            input logic [6:0] vl, vr, input logic mu,
                            input bit late, input logic [15:0] cl2, cr2,
                            input bit extra,
                            output int lat, output int npulse,
                            output logic [15:0] ol, obr);
    exp_t e;
    gl = ramp(gl, int'(vl), mu);
    gr = ramp(gr, int'(vr), mu);
    e.l = mix(late ? cl2 : cl, al, gl);
    e.r = mix(late ? cr2 : cr, ar, gr);
    sb.push_back(e);
    lat = 0; npulse = 0; ol = 16'd0; obr = 16'd0;
    @(negedge clk_sys);
    bus.cdda_l = cl; bus.cdda_r = cr; bus.aud_l = al; bus.aud_r = ar;
    bus.vol_l = vl; bus.vol_r = vr; bus.mute = mu;
    bus.cen_44100 = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.cen_44100 = 1'b0;
    if (late) bus.cdda_l = cl2;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk_sys);
      #1;
      if (bus.out_valid === 1'b1) begin
        if (npulse == 0) begin
          lat = k; ol = bus.out_l; obr = bus.out_r;
        end
        npulse++;
      end
      if (late && k == 1) bus.cdda_r = cr2;
      if (extra && k == 2) bus.cen_44100 = 1'b1;
      if (extra && k == 3) bus.cen_44100 = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat, np;
    logic [15:0] ol, obr;
    exp_t e;
    bus.cen_44100 = 1'b0; bus.cdda_l = 16'd0; bus.cdda_r = 16'd0;
    bus.aud_l = 16'd0; bus.aud_r = 16'd0; bus.vol_l = 7'd0; bus.vol_r = 7'd0;
    bus.mute = 1'b0;
    apply_reset(2);
    #1;
    n_checks++; if (bus.out_l !== 16'd0) begin n_fail++; $display("FAIL reset_out_l: got %h want 0000", bus.out_l); end
    n_checks++; if (bus.out_r !== 16'd0) begin n_fail++; $display("FAIL reset_out_r: got %h want 0000", bus.out_r); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    run_sample(16'h1000, 16'h0000, 16'h0, 16'h0, 7'd64, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL reset_first_pulses: got %0d want 1", np); end
    if (np > 0) begin
      e = sb.pop_front();
      n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL reset_first_l_model: got %h want %h", ol, e.l); end
      n_checks++; if (ol !== 16'h0040) begin n_fail++; $display("FAIL reset_first_l: got %h want 0040", ol); end
    end
  endtask

  task automatic test_ramp_up();
    int lat, np;
    logic [15:0] ol, obr;
    exp_t e;
    apply_reset(2);
    for (int i = 0; i < 64; i++) begin
      run_sample(16'h1000, 16'hF000, 16'h0, 16'h0, 7'd64, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
      n_checks++; if (np !== 1) begin n_fail++; $display("FAIL ramp_pulses[%0d]: got %0d want 1", i, np); end
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL ramp_latency[%0d]: got %0d want 6", i, lat); end
      if (np > 0) begin
        e = sb.pop_front();
        n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL ramp_l[%0d]: got %h want %h", i, ol, e.l); end
        n_checks++; if (obr !== e.r) begin n_fail++; $display("FAIL ramp_r[%0d]: got %h want %h", i, obr, e.r); end
      end
    end
    n_checks++; if (ol !== 16'h1000) begin n_fail++; $display("FAIL ramp_unity_l: got %h want 1000", ol); end
    n_checks++; if (obr !== 16'hF000) begin n_fail++; $display("FAIL ramp_unity_r: got %h want f000", obr); end
  endtask

  task automatic test_saturation();
    int lat, np;
    logic [15:0] ol, obr;
    exp_t e;
    run_sample(16'h7000, 16'h1000, 16'h2000, 16'h0000, 7'd64, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
    if (np > 0) begin
      e = sb.pop_front();
      n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL sat_pos_model: got %h want %h", ol, e.l); end
    end
    n_checks++; if (ol !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_l: got %h want 7fff", ol); end
    n_checks++; if (obr !== 16'h1000) begin n_fail++; $display("FAIL sat_pos_r: got %h want 1000", obr); end
    run_sample(16'h0100, 16'h9000, 16'h0000, 16'hE000, 7'd64, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
    if (np > 0) begin
      e = sb.pop_front();
      n_checks++; if (obr !== e.r) begin n_fail++; $display("FAIL sat_neg_model: got %h want %h", obr, e.r); end
    end
    n_checks++; if (obr !== 16'h8000) begin n_fail++; $display("FAIL sat_neg_r: got %h want 8000", obr); end
    n_checks++; if (ol !== 16'h0100) begin n_fail++; $display("FAIL sat_neg_l: got %h want 0100", ol); end
  endtask

  task automatic test_capture_timing();
    int lat, np;
    logic [15:0] ol, obr;
    exp_t e;
    run_sample(16'h1111, 16'h3333, 16'h0, 16'h0, 7'd64, 7'd64, 1'b0, 1'b1, 16'h2222, 16'h4444, 1'b1, lat, np, ol, obr);
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL cap_ignored_cen: got %0d pulses want 1", np); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL cap_latency: got %0d want 6", lat); end
    if (np > 0) begin
      e = sb.pop_front();
      n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL cap_l_model: got %h want %h", ol, e.l); end
    end
    n_checks++; if (ol !== 16'h2222) begin n_fail++; $display("FAIL cap_late_l: got %h want 2222", ol); end
    n_checks++; if (obr !== 16'h4444) begin n_fail++; $display("FAIL cap_late_r: got %h want 4444", obr); end
  endtask

  task automatic test_mute();
    int lat, np;
    logic [15:0] ol, obr;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      run_sample(16'h1000, 16'h1000, (i == 0) ? 16'h0000 : 16'h0123, 16'h0, 7'd64, 7'd64, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
      if (np > 0) begin
        e = sb.pop_front();
        n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL mute_l[%0d]: got %h want %h", i, ol, e.l); end
        n_checks++; if (obr !== e.r) begin n_fail++; $display("FAIL mute_r[%0d]: got %h want %h", i, obr, e.r); end
      end
      if (i == 0) begin
        n_checks++; if (ol !== 16'h0FC0) begin n_fail++; $display("FAIL mute_first_l: got %h want 0fc0", ol); end
      end
    end
    n_checks++; if (ol !== 16'h0123) begin n_fail++; $display("FAIL mute_settled_l: got %h want 0123", ol); end
    for (int i = 0; i < 64; i++) begin
      run_sample(16'h1000, 16'h1000, 16'h0123, 16'h0, 7'd100, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
      if (np > 0) begin
        e = sb.pop_front();
        n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL vol100_l[%0d]: got %h want %h", i, ol, e.l); end
      end
    end
    n_checks++; if (ol !== 16'h1123) begin n_fail++; $display("FAIL vol100_settled_l: got %h want 1123", ol); end
    n_checks++; if (obr !== 16'h1000) begin n_fail++; $display("FAIL vol100_settled_r: got %h want 1000", obr); end
  endtask

  task automatic test_floor_reset();
    int lat, np, nv;
    logic [15:0] ol, obr;
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      run_sample(16'hFFFF, 16'h0000, 16'h0, 16'h0, 7'd32, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
      if (np > 0) begin
        e = sb.pop_front();
        n_checks++; if (ol !== e.l) begin n_fail++; $display("FAIL floor_l[%0d]: got %h want %h", i, ol, e.l); end
      end
    end
    n_checks++; if (ol !== 16'hFFFF) begin n_fail++; $display("FAIL floor_g32_l: got %h want ffff", ol); end
    // Abort a sample with reset sampled while the FSM is in MUL_R.
    nv = 0;
    @(negedge clk_sys);
    bus.cdda_l = 16'h1000; bus.vol_l = 7'd64; bus.cen_44100 = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.cen_44100 = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_sys);
      #1;
      if (bus.out_valid === 1'b1) nv++;
      if (k == 1) reset = 1'b0;
    end
    gl = 0; gr = 0; sb.delete();
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL midreset_valid: got %0d pulses want 0", nv); end
    n_checks++; if (bus.out_l !== 16'd0) begin n_fail++; $display("FAIL midreset_out_l: got %h want 0000", bus.out_l); end
    n_checks++; if (bus.out_r !== 16'd0) begin n_fail++; $display("FAIL midreset_out_r: got %h want 0000", bus.out_r); end
    run_sample(16'h1000, 16'h1000, 16'h0, 16'h0, 7'd64, 7'd64, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, lat, np, ol, obr);
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL midreset_next_pulses: got %0d want 1", np); end
    if (np > 0) begin
      e = sb.pop_front();
      n_checks++; if (obr !== e.r) begin n_fail++; $display("FAIL midreset_next_r_model: got %h want %h", obr, e.r); end
    end
    n_checks++; if (ol !== 16'h0040) begin n_fail++; $display("FAIL midreset_gain0_l: got %h want 0040", ol); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_saturation();
    test_capture_timing();
    test_mute();
    test_floor_reset();
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
